// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the parametrised UART transceiver.
//   parity_e   - run-time parity selection (code 3 is reserved, behaves as none)
//   tx_state_e - transmit FSM states
//   rx_state_e - receive FSM states
//   par_en()   - true when the parity selection inserts/checks a parity bit
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2,
        PARITY_RSVD = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_PARITY, T_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_PARITY, R_STOP
    } rx_state_e;

    function automatic logic par_en(input parity_e p);
        return (p == PARITY_EVEN) || (p == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divisor down-counter producing the oversample tick.
//   CLK, nRST  - clock, asynchronous active-low reset
//   cfg_div_i  - tick period is cfg_div_i+1 clocks, picked up at each reload
//   tick_o     - one-clock pulse when the counter reaches zero
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);
    assign cnt_d  = tick_o ? cfg_div_i : cnt_q - 1'b1;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_xcvr_param.sv
// uart_xcvr_param: parametrised UART Tx/Rx engine with valid/ready streams.
//   CLK, nRST                  - clock, asynchronous active-low reset
//   cfg_div/parity/stop2/flow_en - baud divisor, parity mode, 2 stop bits, RTS/CTS enable
//   tx_data/tx_valid/tx_ready  - transmit payload stream
//   tx_out, tx_busy            - serial output (idles high), Tx FSM active
//   cts_n, rts_n               - flow control, both active low
//   rx_in                      - asynchronous serial input
//   rx_data/rx_valid/rx_ready  - received payload stream (single holding register)
//   rx_parity_err/rx_frame_err - error flags travelling with rx_data
//   rx_overrun                 - pulse when a completed frame found the holder full
module uart_xcvr_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [DIV_W-1:0]     cfg_div,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    input  logic                 cfg_flow_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    input  logic                 cts_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rts_n,
    output logic                 tx_busy
);

    localparam int              PH_W     = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_HALF  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      BIT_LAST = 4'(DATA_BITS - 1);

    logic    tick;
    parity_e cfg_par;

    assign cfg_par = parity_e'(cfg_parity);

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .CLK       (CLK),
        .nRST      (nRST),
        .cfg_div_i (cfg_div),
        .tick_o    (tick)
    );

    // ---------------- transmitter ----------------
    tx_state_e            tx_state_q, tx_state_d;
    logic [PH_W-1:0]      tx_phase_q, tx_phase_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_pen_q, tx_pen_d;
    logic                 tx_stop2_q, tx_stop2_d;
    logic                 tx_out_q, tx_out_d;
    logic                 cts_s1_q, cts_s2_q;
    logic                 tx_end;

    assign tx_ready = (tx_state_q == T_IDLE) && !(cfg_flow_en && cts_s2_q);
    assign tx_busy  = (tx_state_q != T_IDLE);
    assign tx_out   = tx_out_q;
    assign tx_end   = tick && (tx_phase_q == PH_LAST);

    // tx_out_d is set on the transition into each bit so the line is fully registered
    always_comb begin
        tx_state_d = tx_state_q;
        tx_phase_d = (tx_state_q != T_IDLE && tick) ? tx_phase_q + 1'b1 : tx_phase_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pen_d   = tx_pen_q;
        tx_stop2_d = tx_stop2_q;
        tx_out_d   = tx_out_q;
        case (tx_state_q)
            T_IDLE: if (tx_valid && tx_ready) begin
                tx_state_d = T_START;
                tx_phase_d = '0;
                tx_sh_d    = tx_data;
                tx_par_d   = (^tx_data) ^ (cfg_par == PARITY_ODD);
                tx_pen_d   = par_en(cfg_par);
                tx_stop2_d = cfg_stop2;
                tx_out_d   = 1'b0;
            end
            T_START: if (tx_end) begin
                tx_state_d = T_DATA;
                tx_bit_d   = '0;
                tx_out_d   = tx_sh_q[0];
            end
            T_DATA: if (tx_end) begin
                if (tx_bit_q == BIT_LAST) begin
                    tx_state_d = tx_pen_q ? T_PARITY : T_STOP;
                    tx_out_d   = tx_pen_q ? tx_par_q : 1'b1;
                    tx_bit_d   = '0;
                end else begin
                    tx_bit_d = tx_bit_q + 4'd1;
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_out_d = tx_sh_q[1];
                end
            end
            T_PARITY: if (tx_end) begin
                tx_state_d = T_STOP;
                tx_bit_d   = '0;
                tx_out_d   = 1'b1;
            end
            T_STOP: if (tx_end) begin
                // tx_bit_q counts stop bits already sent
                if (tx_stop2_q && tx_bit_q == 4'd0) tx_bit_d = 4'd1;
                else tx_state_d = T_IDLE;
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tx_state_q <= T_IDLE;
            tx_phase_q <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
            tx_pen_q   <= 1'b0;
            tx_stop2_q <= 1'b0;
            tx_out_q   <= 1'b1;
            cts_s1_q   <= 1'b0;
            cts_s2_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_phase_q <= tx_phase_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_par_q   <= tx_par_d;
            tx_pen_q   <= tx_pen_d;
            tx_stop2_q <= tx_stop2_d;
            tx_out_q   <= tx_out_d;
            cts_s1_q   <= cts_n;
            cts_s2_q   <= cts_s1_q;
        end
    end

    // ---------------- receiver ----------------
    rx_state_e            rx_state_q, rx_state_d;
    logic [PH_W-1:0]      rx_phase_q, rx_phase_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    parity_e              rx_par_q, rx_par_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    logic                 rx_smp, rx_done;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_pe_q, rx_fe_q, rx_ovr_q, rts_q;
    logic                 rx_hs, rx_load;

    assign rx_smp = tick && (rx_phase_q == PH_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_phase_d = (rx_state_q != R_IDLE && tick) ? rx_phase_q + 1'b1 : rx_phase_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_perr_d  = rx_perr_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            R_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = R_START;
                rx_phase_d = '0;
                rx_par_d   = cfg_par;
                rx_perr_d  = 1'b0;
            end
            // half a bit in: still low is a real start, high is a glitch
            R_START: if (tick && rx_phase_q == PH_HALF) begin
                rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
                rx_phase_d = '0;
                rx_bit_d   = '0;
            end
            R_DATA: if (rx_smp) begin
                rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bit_q == BIT_LAST) rx_state_d = par_en(rx_par_q) ? R_PARITY : R_STOP;
                else rx_bit_d = rx_bit_q + 4'd1;
            end
            R_PARITY: if (rx_smp) begin
                rx_perr_d  = rx_s2_q ^ (^rx_sh_q) ^ (rx_par_q == PARITY_ODD);
                rx_state_d = R_STOP;
            end
            R_STOP: if (rx_smp) begin
                rx_done    = 1'b1;
                rx_state_d = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // a same-cycle handshake frees the holder in time for the completing frame
    assign rx_hs   = rx_valid_q && rx_ready;
    assign rx_load = rx_done && (!rx_valid_q || rx_hs);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rx_state_q <= R_IDLE;
            rx_phase_q <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_par_q   <= PARITY_NONE;
            rx_perr_q  <= 1'b0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_pe_q    <= 1'b0;
            rx_fe_q    <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rts_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_phase_q <= rx_phase_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
            rx_s1_q    <= rx_in;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_valid_q <= rx_load || (rx_valid_q && !rx_hs);
            rx_ovr_q   <= rx_done && rx_valid_q && !rx_hs;
            rts_q      <= cfg_flow_en && rx_valid_q;
            if (rx_load) begin
                rx_data_q <= rx_sh_q;
                rx_pe_q   <= rx_perr_q;
                rx_fe_q   <= !rx_s2_q;
            end
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_pe_q;
    assign rx_frame_err  = rx_fe_q;
    assign rx_overrun    = rx_ovr_q;
    assign rts_n         = rts_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// tb_uart_xcvr_param: directed self-checking bench for uart_xcvr_param (8 data bits, x16).
module tb_uart_xcvr_param;
    import uart_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [15:0] cfg_div = '0;
    logic [1:0]  cfg_parity = '0;
    logic        cfg_stop2 = 1'b0;
    logic        cfg_flow_en = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready, tx_out, tx_busy;
    logic        cts_n = 1'b0;
    logic        rx_in, rx_drv = 1'b1, loop = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rts_n;
    logic        rx_ready = 1'b0;

    int   n_tests = 0, n_fail = 0;
    int   ovr_cnt = 0, run = 0;
    logic meas = 1'b0;
    int   runs[$];
    logic [7:0] exp2 [3] = '{8'h00, 8'hFF, 8'h3C};

    assign rx_in = loop ? tx_out : rx_drv;

    always #5 CLK = ~CLK;

    uart_xcvr_param dut (
        .CLK(CLK), .nRST(nRST), .cfg_div(cfg_div), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .cfg_flow_en(cfg_flow_en), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out), .cts_n(cts_n),
        .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun), .rts_n(rts_n), .tx_busy(tx_busy)
    );

    // overrun pulse counter and lengths of high runs on tx_out
    always @(negedge CLK) begin
        if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
        if (meas) begin
            if (tx_out) run <= run + 1;
            else if (run > 0) begin
                runs.push_back(run);
                run <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drives n bits LSB first, 16 clocks each (cfg_div = 0)
    task automatic rx_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge CLK);
        end
    endtask

    task automatic wait_rx_valid();
        for (int i = 0; i < 3000 && !rx_valid; i++) @(negedge CLK);
    endtask

    task automatic rx_take();
        rx_ready = 1'b1;
        @(negedge CLK);
        rx_ready = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !tx_ready; i++) @(negedge CLK);
        check("tx_push_ready", 32'(tx_ready), 1);
        @(negedge CLK);
        tx_valid = 1'b0;
    endtask

    initial begin
        int         low, ovr0;
        logic [9:0] f;
        low = 0;
        // reset values
        repeat (3) @(negedge CLK);
        check("rst_tx_out", 32'(tx_out), 1);
        check("rst_tx_ready", 32'(tx_ready), 1);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_rts_n", 32'(rts_n), 0);
        check("rst_tx_busy", 32'(tx_busy), 0);
        check("rst_errs", {29'd0, rx_parity_err, rx_frame_err, rx_overrun}, 0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        // 8N1 framing of 0xA5, one tick per clock
        f = {1'b1, 8'hA5, 1'b0};
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge CLK);
        tx_valid = 1'b0;
        for (int i = 0; i < 160; i++) begin
            check("t1_bit", 32'(tx_out), 32'(f[i/16]));
            if (!tx_ready) low++;
            @(negedge CLK);
        end
        check("t1_ready_low_cycles", 32'(low), 160);
        check("t1_ready_back", 32'(tx_ready), 1);

        // loopback, div 3, even parity, two stop bits, back-to-back
        cfg_div = 16'd3; cfg_parity = 2'd1; cfg_stop2 = 1'b1;
        loop = 1'b1; rx_ready = 1'b1; meas = 1'b1;
        fork
            begin
                tx_push(8'h00);
                tx_push(8'hFF);
                tx_push(8'h3C);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    wait_rx_valid();
                    check("t2_valid", 32'(rx_valid), 1);
                    check("t2_data", 32'(rx_data), 32'(exp2[k]));
                    check("t2_perr", 32'(rx_parity_err), 0);
                    check("t2_ferr", 32'(rx_frame_err), 0);
                    @(negedge CLK);
                end
            end
        join
        for (int i = 0; i < 3000 && tx_busy; i++) @(negedge CLK);
        meas = 1'b0;
        // runs: idle, stop gap (128 + accept cycle), 0xFF data, stop gap, 0x3C ones
        check("t2_runs", 32'(runs.size()), 5);
        check("t2_gap0", 32'(runs[1]), 129);
        check("t2_ff_run", 32'(runs[2]), 512);
        check("t2_gap1", 32'(runs[3]), 129);
        loop = 1'b0; rx_ready = 1'b0; cfg_div = '0; cfg_stop2 = 1'b0;
        repeat (8) @(negedge CLK);

        // wrong (odd) parity bit on 0x01 under even parity
        rx_bits(16'({1'b1, 1'b0, 8'h01, 1'b0}), 11);
        wait_rx_valid();
        check("t3_pe_data", 32'(rx_data), 32'h01);
        check("t3_pe_perr", 32'(rx_parity_err), 1);
        check("t3_pe_ferr", 32'(rx_frame_err), 0);
        rx_take();
        // stop bit low, no parity
        cfg_parity = 2'd0;
        rx_bits(16'({1'b0, 8'h55, 1'b0}), 10);
        rx_drv = 1'b1;
        repeat (16) @(negedge CLK);
        wait_rx_valid();
        check("t3_fe_data", 32'(rx_data), 32'h55);
        check("t3_fe_ferr", 32'(rx_frame_err), 1);
        check("t3_fe_perr", 32'(rx_parity_err), 0);
        rx_take();

        // 4-tick glitch is a false start
        rx_drv = 1'b0;
        repeat (4) @(negedge CLK);
        rx_drv = 1'b1;
        repeat (40) @(negedge CLK);
        check("t4_no_valid", 32'(rx_valid), 0);
        check("t4_idle", 32'(dut.rx_state_q), 32'(R_IDLE));

        // overrun with consumer stalled
        ovr0 = ovr_cnt;
        rx_bits(16'({1'b1, 8'h11, 1'b0}), 10);
        repeat (16) @(negedge CLK);
        rx_bits(16'({1'b1, 8'h22, 1'b0}), 10);
        repeat (20) @(negedge CLK);
        check("t5_ovr_valid", 32'(rx_valid), 1);
        check("t5_ovr_data", 32'(rx_data), 32'h11);
        check("t5_ovr_pulses", 32'(ovr_cnt - ovr0), 1);
        rx_take();
        check("t5_cleared", 32'(rx_valid), 0);

        // handshake lands on the completion cycle: stop mid-point is the 155th
        // rising edge after the start bit is driven (2 sync + 1 detect + 8 + 9*16)
        ovr0 = ovr_cnt;
        rx_bits(16'({1'b1, 8'h11, 1'b0}), 10);
        repeat (16) @(negedge CLK);
        check("t5_hold_data", 32'(rx_data), 32'h11);
        fork
            rx_bits(16'({1'b1, 8'h22, 1'b0}), 10);
            begin
                repeat (154) @(negedge CLK);
                rx_ready = 1'b1;
                @(negedge CLK);
                rx_ready = 1'b0;
            end
        join
        repeat (4) @(negedge CLK);
        check("t5_same_valid", 32'(rx_valid), 1);
        check("t5_same_data", 32'(rx_data), 32'h22);
        check("t5_same_no_ovr", 32'(ovr_cnt - ovr0), 0);

        // flow control: CTS holds Tx off, RTS reflects the full holder
        cfg_flow_en = 1'b1;
        cts_n = 1'b1;
        repeat (4) @(negedge CLK);
        check("t6_ready_gated", 32'(tx_ready), 0);
        check("t6_rts", 32'(rts_n), 1);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        repeat (50) @(negedge CLK);
        check("t6_not_busy", 32'(tx_busy), 0);
        check("t6_line_idle", 32'(tx_out), 1);
        cts_n = 1'b0;
        for (int i = 0; i < 100 && !tx_ready; i++) @(negedge CLK);
        @(negedge CLK);
        tx_valid = 1'b0;
        check("t6_busy", 32'(tx_busy), 1);
        repeat (20) @(negedge CLK);
        check("t6_data_bit0", 32'(tx_out), 0);
        // asynchronous reset mid-data
        nRST = 1'b0;
        #1;
        check("t6_rst_tx_out", 32'(tx_out), 1);
        check("t6_rst_busy", 32'(tx_busy), 0);
        check("t6_rst_ready", 32'(tx_ready), 1);
        check("t6_rst_rx_valid", 32'(rx_valid), 0);
        check("t6_rst_rts", 32'(rts_n), 0);
        check("t6_rst_errs", {29'd0, rx_parity_err, rx_frame_err, rx_overrun}, 0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
